// File: rtl/risc_pkg.sv
// Shared RISC core definitions: register file geometry, register address type
// and the hardwired-zero register index. Used by the reg-dest mux, decode and
// the register file / scoreboard.
package risc_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 3'd0;

    // True when the address names a real (writable, trackable) register.
    function automatic logic is_real_reg(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Write scoreboard for the register file.
// Tracks one busy bit per register, sets it on an accepted issue, clears it on
// writeback, and generates the RAW/WAW issue stall.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   rd_addr_a, rd_addr_b        source operand addresses
//   issue_valid, issue_addr     instruction presenting a destination write
//   issue_uses_a, issue_uses_b  instruction reads port A / port B
//   wb_valid, wb_addr           writeback strobe and destination
//   stall                       combinational issue hold
//   busy                        registered pending-write vector (bit 0 always 0)
module reg_scoreboard
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W = risc_pkg::REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     issue_uses_a,
    input  logic                     issue_uses_b,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    output logic                     stall,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int unsigned NUM_ENT = 2**ADDR_W;

    logic [NUM_ENT-1:0] wb_clr;
    logic [NUM_ENT-1:0] eff_busy;
    logic [NUM_ENT-1:0] issue_set;
    logic [NUM_ENT-1:0] busy_nxt;
    logic               hazard_a;
    logic               hazard_b;
    logic               hazard_waw;
    logic               accept;

    // Clear/set decode, hazard detection and next busy vector.
    always_comb begin
        wb_clr     = '0;
        issue_set  = '0;
        eff_busy   = '0;
        busy_nxt   = '0;
        hazard_a   = 1'b0;
        hazard_b   = 1'b0;
        hazard_waw = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;

        // r0 is skipped so it can never be cleared or set.
        for (int unsigned i = 1; i < NUM_ENT; i++) begin
            wb_clr[i] = wb_valid && (wb_addr == ADDR_W'(i));
        end

        // A writeback landing this cycle already resolves its hazard.
        eff_busy = busy & ~wb_clr;

        hazard_a   = issue_uses_a && eff_busy[rd_addr_a];
        hazard_b   = issue_uses_b && eff_busy[rd_addr_b];
        hazard_waw = eff_busy[issue_addr];

        stall  = issue_valid && (hazard_a || hazard_b || hazard_waw);
        accept = issue_valid && !stall;

        for (int unsigned i = 1; i < NUM_ENT; i++) begin
            issue_set[i] = accept && (issue_addr == ADDR_W'(i));
        end

        // Set after clear so a same-register issue/writeback leaves it busy.
        busy_nxt = eff_busy | issue_set;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Eight-entry register file with integrated write scoreboard.
// Holds the data array and read bypass; the busy/stall bookkeeping lives in
// reg_scoreboard.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   rd_addr_a/b, rd_data_a/b    two combinational read ports with wb bypass
//   issue_valid, issue_addr     decode destination from the reg-dest mux
//   issue_uses_a/b              instruction reads port A / port B
//   stall                       combinational issue hold (RAW/WAW)
//   wb_valid, wb_addr, wb_data  writeback
//   busy                        registered pending-write vector
module reg_file_sb
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = risc_pkg::DATA_W,
    parameter int unsigned ADDR_W = risc_pkg::REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_a,
    output logic [DATA_W-1:0]        rd_data_b,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     issue_uses_a,
    input  logic                     issue_uses_b,
    output logic                     stall,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int unsigned NUM_ENT = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [NUM_ENT];
    logic              wb_write;

    assign wb_write = wb_valid && (wb_addr != ZERO_ADDR);

    // Data array; r0 is never written so it holds zero from reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_write) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // Read port A: r0 forced to zero, otherwise same-cycle writeback bypass.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (rd_addr_a == ZERO_ADDR) begin
            rd_data_a = '0;
        end else if (wb_valid && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if (rd_addr_b == ZERO_ADDR) begin
            rd_data_b = '0;
        end else if (wb_valid && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .issue_uses_a (issue_uses_a),
        .issue_uses_b (issue_uses_b),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .stall        (stall),
        .busy         (busy)
    );

endmodule
